// File: rtl/alu_sched_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification helpers
// for the ALU operation scheduler.
package alu_sched_pkg;

    localparam logic [3:0] OPC_AND   = 4'b0000;
    localparam logic [3:0] OPC_NAND  = 4'b0001;
    localparam logic [3:0] OPC_OR    = 4'b0010;
    localparam logic [3:0] OPC_XOR   = 4'b0011;
    localparam logic [3:0] OPC_XNOR  = 4'b0100;
    localparam logic [3:0] OPC_NOR   = 4'b0101;
    localparam logic [3:0] OPC_NOT   = 4'b0110;
    localparam logic [3:0] OPC_ADD   = 4'b0111;
    localparam logic [3:0] OPC_SUB   = 4'b1000;
    localparam logic [3:0] OPC_MUL   = 4'b1001;
    localparam logic [3:0] OPC_SHIFT = 4'b1010;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    function automatic logic is_legal_opc(input logic [3:0] opc);
        return (opc <= OPC_SHIFT);
    endfunction

    function automatic logic is_mul_opc(input logic [3:0] opc);
        return (opc == OPC_MUL);
    endfunction

    // Only the arithmetic add/subtract ops produce a meaningful carry/borrow.
    function automatic logic has_cout_opc(input logic [3:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

endpackage

// File: rtl/alu_op_scheduler_arbiter.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant
// is actually accepted, so a stalled grant keeps its priority.
module alu_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant,
    output logic any,
    output logic accept
);

    logic last_grant_r;

    // Pick the only requester, or the one that did not win last time.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant_r;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
        any    = valid0 | valid1;
        accept = enable & (valid0 | valid1);
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (accept) begin
            last_grant_r <= grant;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Arbitrating front-end for the shared 4-bit ALU: one op in flight, registered
// ALU drive and response. Optional counters under macro ALU_SCHED_STATS_EN.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int OPC_W   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OPC_W-1:0]    req0_opcode,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic                req0_cin,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OPC_W-1:0]    req1_opcode,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    input  logic                req1_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [2*DATA_W-1:0] rsp_y,
    output logic                rsp_cout,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic                alu_cin,
    output logic [OPC_W-1:0]    alu_opcode,
    input  logic [DATA_W-1:0]   alu_y,
    input  logic [2*DATA_W-1:0] alu_y8,
`ifdef ALU_SCHED_STATS_EN
    output logic [15:0]         stat_grant0,
    output logic [15:0]         stat_grant1,
    output logic [7:0]          stat_err,
`endif
    input  logic                alu_cout
);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

    sched_state_e      state_r;
    sched_state_e      state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              grant_s;
    logic              any_s;
    logic              accept_s;
    logic              capture_s;
    logic              rsp_hs_s;
    logic              legal_s;
    logic [OPC_W-1:0]  sel_opc_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic              sel_cin_s;

    alu_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable (state_r == IDLE),
        .grant  (grant_s),
        .any    (any_s),
        .accept (accept_s)
    );

    // Payload of the granted requester.
    always_comb begin
        if (grant_s) begin
            sel_opc_s = req1_opcode;
            sel_a_s   = req1_a;
            sel_b_s   = req1_b;
            sel_cin_s = req1_cin;
        end else begin
            sel_opc_s = req0_opcode;
            sel_a_s   = req0_a;
            sel_b_s   = req0_b;
            sel_cin_s = req0_cin;
        end
        legal_s = is_legal_opc(sel_opc_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; illegal opcodes skip EXEC entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = legal_s ? EXEC : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake/strobe decode from the current state.
    always_comb begin
        req0_ready = (state_r == IDLE) & any_s & ~grant_s;
        req1_ready = (state_r == IDLE) & any_s & grant_s;
        capture_s  = (state_r == EXEC) && (cnt_r == {CNT_W{1'b0}});
        rsp_hs_s   = (state_r == RESP) & rsp_ready;
    end

    // ALU drive and response registers; alu_* only move on a legal accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            alu_a      <= {DATA_W{1'b0}};
            alu_b      <= {DATA_W{1'b0}};
            alu_cin    <= 1'b0;
            alu_opcode <= {OPC_W{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= {(2*DATA_W){1'b0}};
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept_s) begin
            rsp_id <= grant_s;
            if (legal_s) begin
                alu_a      <= sel_a_s;
                alu_b      <= sel_b_s;
                alu_cin    <= sel_cin_s;
                alu_opcode <= sel_opc_s;
                cnt_r      <= is_mul_opc(sel_opc_s) ? MUL_CNT_INIT : {CNT_W{1'b0}};
            end else begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_y     <= {(2*DATA_W){1'b0}};
                rsp_cout  <= 1'b0;
            end
        end else if (capture_s) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_y     <= is_mul_opc(alu_opcode) ? alu_y8 : {{DATA_W{1'b0}}, alu_y};
            rsp_cout  <= has_cout_opc(alu_opcode) ? alu_cout : 1'b0;
        end else if (state_r == EXEC) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (rsp_hs_s) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    // Saturating per-requester accept counters and illegal-opcode counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0 <= 16'd0;
            stat_grant1 <= 16'd0;
            stat_err    <= 8'd0;
        end else if (accept_s) begin
            if (!grant_s && (stat_grant0 != 16'hFFFF)) begin
                stat_grant0 <= stat_grant0 + 16'd1;
            end
            if (grant_s && (stat_grant1 != 16'hFFFF)) begin
                stat_grant1 <= stat_grant1 + 16'd1;
            end
            if (!legal_s && (stat_err != 8'hFF)) begin
                stat_err <= stat_err + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed, table-driven bench for alu_op_scheduler with a behavioural ALU stub.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_opcode = 4'd0, req1_opcode = 4'd0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       req0_cin = 1'b0, req1_cin = 1'b0;
    logic       rsp_valid, rsp_id, rsp_cout, rsp_err;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_y;
    logic [3:0] alu_a, alu_b, alu_opcode;
    logic       alu_cin;
    logic [3:0] alu_y;
    logic [7:0] alu_y8;
    logic       alu_cout;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_scheduler #(.DATA_W(4), .OPC_W(4), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_y8(alu_y8), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // ALU stub; cout and y8 carry junk on ops where they must be ignored.
    always_comb begin
        logic [4:0] t;
        t        = 5'd0;
        alu_y    = 4'd0;
        alu_y8   = 8'h5A;
        alu_cout = ^alu_a;
        case (alu_opcode)
            OPC_AND:   alu_y = alu_a & alu_b;
            OPC_NAND:  alu_y = ~(alu_a & alu_b);
            OPC_OR:    alu_y = alu_a | alu_b;
            OPC_XOR:   alu_y = alu_a ^ alu_b;
            OPC_XNOR:  alu_y = ~(alu_a ^ alu_b);
            OPC_NOR:   alu_y = ~(alu_a | alu_b);
            OPC_NOT:   alu_y = ~alu_a;
            OPC_ADD: begin
                t = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
                alu_y = t[3:0];
                alu_cout = t[4];
            end
            OPC_SUB: begin
                t = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_cin};
                alu_y = t[3:0];
                alu_cout = t[4];
            end
            OPC_MUL: begin
                alu_y8 = {4'd0, alu_a} * {4'd0, alu_b};
                alu_y  = alu_y8[3:0];
            end
            OPC_SHIFT: alu_y = alu_a << alu_b[1:0];
            default:   alu_y = 4'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       req;
        logic [3:0] opc;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [7:0] exp_y;
        logic       exp_cout;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[13];
    logic [3:0] prev_opc = 4'd0;
    logic [3:0] prev_a   = 4'd0;

    task automatic drive_req(input logic r, input logic [3:0] opc, input logic [3:0] a,
                             input logic [3:0] b, input logic cin);
        if (r) begin
            req1_valid = 1'b1; req1_opcode = opc; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_opcode = opc; req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    // Present one request and return once its handshake edge has passed.
    task automatic issue(input logic r, input logic [3:0] opc, input logic [3:0] a,
                         input logic [3:0] b, input logic cin);
        int w;
        @(negedge clk);
        drive_req(r, opc, a, b, cin);
        #1;
        w = 0;
        while (((r ? req1_ready : req0_ready) !== 1'b1) && (w < 20)) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 20) chk("ready_timeout", 32'(w), 32'd0);
        @(posedge clk);
        #1;
        if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   cyc;
        v = vecs[i];
        issue(v.req, v.opc, v.a, v.b, v.cin);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) break;
            if (!v.exp_err) begin
                chk("alu_opcode_hold", 32'(alu_opcode), 32'(v.opc));
                chk("alu_a_hold", 32'(alu_a), 32'(v.a));
            end
        end
        chk("latency", 32'(cyc), 32'(v.exp_lat));
        chk("rsp_y", 32'(rsp_y), 32'(v.exp_y));
        chk("rsp_cout", 32'(rsp_cout), 32'(v.exp_cout));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("rsp_id", 32'(rsp_id), 32'(v.req));
        if (v.exp_err) begin
            chk("illegal_alu_opc_kept", 32'(alu_opcode), 32'(prev_opc));
            chk("illegal_alu_a_kept", 32'(alu_a), 32'(prev_a));
        end else begin
            prev_opc = v.opc;
            prev_a   = v.a;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic g[$];
        logic rids[$];
        int   cyc;

        vecs[0]  = '{1'b0, OPC_ADD,   4'h7, 4'h1, 1'b0, 8'h08, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b1, OPC_MUL,   4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b0, OPC_ADD,   4'hF, 4'h1, 1'b1, 8'h01, 1'b1, 1'b0, 2};
        vecs[3]  = '{1'b1, OPC_SUB,   4'h3, 4'h5, 1'b0, 8'h0E, 1'b1, 1'b0, 2};
        vecs[4]  = '{1'b0, OPC_AND,   4'hD, 4'hA, 1'b0, 8'h08, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b1, OPC_XOR,   4'hD, 4'h6, 1'b0, 8'h0B, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, OPC_NOT,   4'h7, 4'h0, 1'b0, 8'h08, 1'b0, 1'b0, 2};
        vecs[7]  = '{1'b0, OPC_SHIFT, 4'h3, 4'h2, 1'b0, 8'h0C, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b0, 4'b1100,   4'hF, 4'hF, 1'b1, 8'h00, 1'b0, 1'b1, 1};
        vecs[9]  = '{1'b1, 4'b1011,   4'h9, 4'h9, 1'b0, 8'h00, 1'b0, 1'b1, 1};
        vecs[10] = '{1'b1, OPC_MUL,   4'h7, 4'h3, 1'b0, 8'h15, 1'b0, 1'b0, 3};
        vecs[11] = '{1'b0, 4'b1111,   4'h2, 4'h2, 1'b0, 8'h00, 1'b0, 1'b1, 1};
        vecs[12] = '{1'b0, OPC_NOR,   4'h1, 4'h2, 1'b0, 8'h0C, 1'b0, 1'b0, 2};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_y", 32'(rsp_y), 32'd0);
        chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);

        for (int i = 0; i < 13; i++) run_vec(i);

        // Continuous contention: grants must alternate, starting opposite the last winner (req0).
        rsp_ready = 1'b1;
        @(negedge clk);
        drive_req(1'b0, OPC_ADD, 4'h1, 4'h1, 1'b0);
        drive_req(1'b1, OPC_OR, 4'h4, 4'h1, 1'b0);
        cyc = 0;
        while ((rids.size() < 4) && (cyc < 60)) begin
            #1;
            chk("both_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_ready) g.push_back(1'b0);
            if (req1_ready) g.push_back(1'b1);
            if (rsp_valid) rids.push_back(rsp_id);
            if (rids.size() < 4) @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_grant_count", 32'(g.size()), 32'd4);
        chk("rr_rsp_count", 32'(rids.size()), 32'd4);
        if ((g.size() == 4) && (rids.size() == 4)) begin
            chk("rr_first_grant", 32'(g[0]), 32'd1);
            for (int i = 1; i < 4; i++) chk("rr_alternate", 32'(g[i] ^ g[i-1]), 32'd1);
            for (int i = 0; i < 4; i++) chk("rr_rsp_id_order", 32'(rids[i]), 32'(g[i]));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Response backpressure for 5 cycles with a competing requester waiting.
        issue(1'b0, OPC_ADD, 4'h2, 4'h3, 1'b0);
        cyc = 0;
        while ((rsp_valid !== 1'b1) && (cyc < 20)) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd2);
        drive_req(1'b1, OPC_XOR, 4'h5, 4'h3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_y", 32'(rsp_y), 32'h05);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_resume_ready", 32'(req1_ready), 32'd1);
        chk("bp_rsp_valid_low", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        cyc = 0;
        while ((rsp_valid !== 1'b1) && (cyc < 20)) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_second_y", 32'(rsp_y), 32'h06);
        chk("bp_second_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset during a req0 multiply: no response, outputs cleared, req0 wins next.
        issue(1'b0, OPC_MUL, 4'h6, 4'h5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        drive_req(1'b0, OPC_ADD, 4'h1, 4'h2, 1'b0);
        drive_req(1'b1, OPC_ADD, 4'h3, 4'h4, 1'b0);
        #1;
        chk("rst_grant_req0", 32'({req1_ready, req0_ready}), 32'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
